packet_builder: RTL

- BFT transmit-side framer; the counterpart of the BFT receive-side parser that splits incoming packets into data and config streams.
- Accepts outgoing stream data and config/response traffic from two valid/ready channels. Buffers each channel in a small FIFO.
- Prepends the valid/leaf/port header and round-robin arbitrates between the two FIFOs.
- Presents one packet at a time on the BFT output, held until the BFT accepts it.

---
 rtl/packet_builder_pkg.sv | 35 +++
 rtl/packet_builder_fifo.sv | 54 +++++
 rtl/packet_builder.sv | 119 +++++++++++
 3 files changed

// File: rtl/packet_builder_pkg.sv
// Shared BFT framing definitions: the port-range constants, the header field offsets
// and the packet layout. The parser and the builder both import this package.
package packet_builder_pkg;

    localparam int unsigned INPUT_PORT_MAX_NUM  = 8;
    localparam int unsigned OUTPUT_PORT_MIN_NUM = 9;
    localparam int unsigned DATA_PORT_MIN_NUM   = 2;

    localparam int PKT_BITS  = 97;
    localparam int LEAF_BITS = 6;
    localparam int PORT_BITS = 4;
    localparam int PLD_BITS  = PKT_BITS - 1 - LEAF_BITS - PORT_BITS;

    typedef struct packed {
        logic                 valid;
        logic [LEAF_BITS-1:0] leaf;
        logic [PORT_BITS-1:0] port;
        logic [PLD_BITS-1:0]  payload;
    } packet_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } out_state_e;

    // Header fields sit directly above the payload: the port first, then the leaf.
    function automatic int hdr_port_lsb(input int payload_bits);
        return payload_bits;
    endfunction

    function automatic int hdr_leaf_lsb(input int payload_bits, input int port_bits);
        return payload_bits + port_bits;
    endfunction

endpackage

// File: rtl/packet_builder_fifo.sv
// Small synchronous FIFO with a show-ahead read port and full/empty flags.
module packet_builder_fifo
    import packet_builder_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_wdata;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/packet_builder.sv
// BFT transmit framer: buffers data and config beats, prepends the valid/leaf/port
// header and round-robins the two queues onto a single held output register.
module packet_builder
    import packet_builder_pkg::*;
#(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int PAYLOAD_BITS  = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PAYLOAD_BITS-1:0]  i_data_payload,
    input  logic [NUM_LEAF_BITS-1:0] i_data_leaf,
    input  logic [NUM_PORT_BITS-1:0] i_data_port,
    input  logic                     i_data_valid,
    output logic                     o_data_ready,
    input  logic [PAYLOAD_BITS-1:0]  i_cfg_payload,
    input  logic [NUM_LEAF_BITS-1:0] i_cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0] i_cfg_port,
    input  logic                     i_cfg_valid,
    output logic                     o_cfg_ready,
    output logic [PACKET_BITS-1:0]   o_bft_data,
    input  logic                     i_bft_ready,
    output logic [15:0]              o_drop_count
);
    localparam int ENTRY_W  = PACKET_BITS - 1;
    localparam int PORT_LSB = hdr_port_lsb(PAYLOAD_BITS);
    localparam int LEAF_LSB = hdr_leaf_lsb(PAYLOAD_BITS, NUM_PORT_BITS);

    logic [ENTRY_W-1:0]     w_data_entry, w_cfg_entry;
    logic [ENTRY_W-1:0]     w_data_head, w_cfg_head;
    logic                   w_data_full, w_data_empty, w_cfg_full, w_cfg_empty;
    logic                   w_data_legal, w_cfg_legal;
    logic                   w_data_acc, w_cfg_acc;
    logic [1:0]             w_drop_inc;
    logic [16:0]            w_drop_sum;
    logic                   w_any, w_load, w_grant_cfg;
    out_state_e             r_state;
    logic [PACKET_BITS-1:0] r_bft;
    logic                   r_last_cfg;
    logic [15:0]            r_drop;

    always_comb begin
        w_data_entry = '0;
        w_data_entry[PAYLOAD_BITS-1:0]          = i_data_payload;
        w_data_entry[PORT_LSB +: NUM_PORT_BITS] = i_data_port;
        w_data_entry[LEAF_LSB +: NUM_LEAF_BITS] = i_data_leaf;
        w_cfg_entry = '0;
        w_cfg_entry[PAYLOAD_BITS-1:0]           = i_cfg_payload;
        w_cfg_entry[PORT_LSB +: NUM_PORT_BITS]  = i_cfg_port;
        w_cfg_entry[LEAF_LSB +: NUM_LEAF_BITS]  = i_cfg_leaf;
    end

    // Data goes to input ports, config/responses to the low or output-side ports.
    assign w_data_legal = (32'(i_data_port) >= DATA_PORT_MIN_NUM) &&
                          (32'(i_data_port) <= INPUT_PORT_MAX_NUM);
    assign w_cfg_legal  = (32'(i_cfg_port) < DATA_PORT_MIN_NUM) ||
                          (32'(i_cfg_port) >= OUTPUT_PORT_MIN_NUM);

    assign o_data_ready = ~w_data_full & ~reset;
    assign o_cfg_ready  = ~w_cfg_full & ~reset;
    assign w_data_acc   = i_data_valid & o_data_ready;
    assign w_cfg_acc    = i_cfg_valid & o_cfg_ready;

    assign w_drop_inc = {1'b0, w_data_acc & ~w_data_legal} + {1'b0, w_cfg_acc & ~w_cfg_legal};
    assign w_drop_sum = {1'b0, r_drop} + {15'b0, w_drop_inc};

    // Config wins only when data is absent or data was granted last.
    assign w_any       = ~w_data_empty | ~w_cfg_empty;
    assign w_load      = w_any & ((r_state == ST_IDLE) | i_bft_ready);
    assign w_grant_cfg = ~w_cfg_empty & (w_data_empty | ~r_last_cfg);

    packet_builder_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_data_acc & w_data_legal),
        .i_wdata (w_data_entry),
        .i_pop   (w_load & ~w_grant_cfg),
        .o_rdata (w_data_head),
        .o_full  (w_data_full),
        .o_empty (w_data_empty)
    );

    packet_builder_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_cfg_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_cfg_acc & w_cfg_legal),
        .i_wdata (w_cfg_entry),
        .i_pop   (w_load & w_grant_cfg),
        .o_rdata (w_cfg_head),
        .o_full  (w_cfg_full),
        .o_empty (w_cfg_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_bft      <= '0;
            r_last_cfg <= 1'b1;
            r_drop     <= '0;
        end else begin
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_load) begin
                r_state    <= ST_HOLD;
                r_bft      <= {1'b1, w_grant_cfg ? w_cfg_head : w_data_head};
                r_last_cfg <= w_grant_cfg;
            end else if (r_state == ST_HOLD && i_bft_ready) begin
                r_state <= ST_IDLE;
                r_bft   <= '0;
            end
        end
    end

    assign o_bft_data   = r_bft;
    assign o_drop_count = r_drop;

endmodule
